karatsuba_mul_sequencer: RTL and testbench
==========================================

# karatsuba_mul_sequencer

- Upstream operand/result sequencer for the 32-bit iterative Karatsuba multiplier, `iterative_karatsuba_32_16`.
- Accepts operand pairs over a valid/ready handshake and holds them stable for the multiplier.
- Issues the multiplier's synchronous clear, then holds its enable for a fixed number of cycles.
- Captures the 64-bit product and presents it downstream over a second valid/ready handshake, with an error flag if the multiplier never signalled done.

## Interface
- `W`, 32: operand width; product width is 2*W.
- `MUL_CYCLES`, 6: number of cycles `mul_en` is held high per operation; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can accept an operand pair.
- `in_a` in W: operand A.
- `in_b` in W: operand B.
- `out_valid` out 1: product valid.
- `out_ready` in 1: downstream accepts the product.
- `out_c` out 2W: captured product.
- `out_err` out 1: `mul_done` was low at capture for this product.
- `busy` out 1: high in any state except IDLE.
- `mul_rst` out 1: drives the multiplier's `rst`.
- `mul_en` out 1: drives the multiplier's `enable`.
- `mul_a` out W: drives the multiplier's `A`.
- `mul_b` out W: drives the multiplier's `B`.
- `mul_c` in 2W: product from the multiplier's `C`.
- `mul_done` in 1: multiplier's internal done; tie to 1 if it is not brought out.

## Operation

**States:** IDLE, CLR, RUN, CAP, HOLD. The encoding is free. Every output except `mul_rst` and `in_ready` is registered.

**Reset values (asynchronous, while `rst` is high):**
- State is IDLE and the counter is 0.
- `out_valid`, `out_err`, `mul_en` and `busy` are 0.
- `out_c`, `mul_a` and `mul_b` are 0.
- `mul_rst` is 1, because it is defined as `rst` OR (state==CLR), so the multiplier is cleared together with the sequencer.
- `in_ready` is 0 while `rst` is high and 1 once reset is released (the state is IDLE).

**Handshakes:**
- An input transfer happens on any edge where `in_valid` and `in_ready` are both high.
- An output transfer happens on any edge where `out_valid` and `out_ready` are both high.
- `in_ready` = (state==IDLE) OR (state==HOLD AND `out_ready`).

**Transitions:**
- IDLE: on an input transfer, latch `in_a`/`in_b` into `mul_a`/`mul_b` and go to CLR. Otherwise stay in IDLE.
- CLR: `mul_rst` is high for exactly one cycle and the counter is cleared. Go to RUN.
- RUN: `mul_en` is high and the counter increments each cycle. When counter == `MUL_CYCLES`-1, go to CAP and drop `mul_en`.
- CAP: `mul_en` is low.
  - On the exit edge, `out_c` <= `mul_c`, `out_err` <= ~`mul_done`, and `out_valid` <= 1.
  - Go to HOLD.
- HOLD: `out_valid` is high and `out_c`/`out_err` are held.
  - On an output transfer with `in_valid` low: clear `out_valid` and go to IDLE.
  - On an output transfer with `in_valid` high (simultaneous event): clear `out_valid`, latch the new operands and go straight to CLR. No idle bubble is inserted.
  - With no output transfer: stay in HOLD; the product is never overwritten or dropped.

**Stability and arithmetic:**
- `mul_a`/`mul_b` change only on an input transfer. They are stable from CLR through HOLD.
- `out_c` changes only on the CAP exit edge and on reset.
- Arithmetic is unsigned and the product is taken verbatim from `mul_c`. The sequencer performs no arithmetic itself.
- The counter is 8 bits wide and never wraps during RUN, because it is compared against `MUL_CYCLES`-1 ≤ 254.

**Fault behaviour:** `out_err` is informational only. The product is still delivered and the FSM sequence is unchanged.

## Timing
- The accepting edge is edge 0. Then:
  - CLR occupies the cycle after edge 0.
  - RUN occupies edges 1..`MUL_CYCLES`.
  - CAP follows RUN.
  - `out_valid` rises after edge `MUL_CYCLES`+2, which is edge 8 at the default.
- Back-to-back throughput with `out_ready` held high is one product every `MUL_CYCLES`+3 cycles, i.e. 9 at the default.
- `mul_rst` is high for exactly 1 cycle per operation and `mul_en` for exactly `MUL_CYCLES` consecutive cycles.
- Asserting `rst` mid-operation (in any state) immediately aborts the operation and discards the operands and any held product. No `out_valid` is produced for the aborted operation.
- `busy` goes high on the cycle after the accepting edge and low on the cycle after the final output transfer that returns the FSM to IDLE.

## Test plan
- Single operation, with the sequencer connected to `iterative_karatsuba_32_16` and `out_ready`=1:
  - Stimulus: A=0x0000_1234, B=0x0000_5678.
  - Required: `out_c`=0x0000_0000_0626_0060 and `out_err`=0.
  - Required: `out_valid` rises 8 edges after acceptance.
- Full-scale operands:
  - Stimulus: A=B=0xFFFF_FFFF.
  - Required: `out_c`=0xFFFF_FFFE_0000_0001.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid` rises, with `in_valid`=1 throughout.
  - Required: `in_ready` stays 0, `out_c` is stable, and `mul_en` stays 0 throughout.
  - Required: when `out_ready` is raised, the next operand pair is accepted on the same edge.
- Back-to-back:
  - Stimulus: 3 pairs with continuous `in_valid`/`out_ready`: (3,5), (0x8000_0000,2), (0,0xDEAD_BEEF).
  - Required: products 15, 0x1_0000_0000 and 0, delivered 9 cycles apart in order.
- Done fault:
  - Stimulus: drive `mul_done`=0 from a stub multiplier that returns `mul_c`=0x0123.
  - Required: `out_c`=0x0123 and `out_err`=1.
  - Required: the next operation, run with `mul_done`=1, gives `out_err`=0.
- Reset mid-RUN:
  - Stimulus: assert `rst` asynchronously, between clock edges, on the 3rd RUN cycle.
  - Required: `mul_en`, `busy` and `out_valid` fall immediately and `mul_rst`=1.
  - Required: after release, `in_ready`=1 and a new operation (7×9) returns 63.

Source files
------------

// File: rtl/karatsuba_mul_sequencer_if.sv
// Operand and product handshake bundle between a client and karatsuba_mul_sequencer.
// The client side is the master; the sequencer is the slave.
interface karatsuba_mul_sequencer_if #(
    parameter int W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_c;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c, out_err
    );
endinterface

// File: rtl/karatsuba_mul_sequencer.sv
// Sequencer for iterative_karatsuba_32_16: latches operands, pulses the multiplier clear,
// holds enable for MUL_CYCLES cycles, then captures and presents the product.
module karatsuba_mul_sequencer #(
    parameter int W          = 32,
    parameter int MUL_CYCLES = 6
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    karatsuba_mul_sequencer_if.slave bus,
    output logic                    o_busy,
    output logic                    o_mul_rst,
    output logic                    o_mul_en,
    output logic [W-1:0]            o_mul_a,
    output logic [W-1:0]            o_mul_b,
    input  logic [2*W-1:0]          i_mul_c,
    input  logic                    i_mul_done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_CAP,
        S_HOLD
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MUL_CYCLES - 1);

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic             r_busy;
    logic             r_mul_en;
    logic [W-1:0]     r_mul_a;
    logic [W-1:0]     r_mul_b;
    logic             r_out_valid;
    logic [2*W-1:0]   r_out_c;
    logic             r_out_err;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    // HOLD may accept new operands in the same edge as the product leaves.
    assign w_in_ready = ~i_rst & ((r_state == S_IDLE) |
                                  ((r_state == S_HOLD) & bus.out_ready));
    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_c     = r_out_c;
    assign bus.out_err   = r_out_err;

    assign o_mul_rst = i_rst | (r_state == S_CLR);
    assign o_mul_en  = r_mul_en;
    assign o_mul_a   = r_mul_a;
    assign o_mul_b   = r_mul_b;
    assign o_busy    = r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_busy      <= 1'b0;
            r_mul_en    <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_mul_a <= bus.in_a;
                        r_mul_b <= bus.in_b;
                        r_busy  <= 1'b1;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_cnt    <= 8'd0;
                    r_mul_en <= 1'b1;
                    r_state  <= S_RUN;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == LAST_CNT) begin
                        r_mul_en <= 1'b0;
                        r_state  <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_out_c     <= i_mul_c;
                    r_out_err   <= ~i_mul_done;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        if (bus.in_valid) begin
                            r_mul_a <= bus.in_a;
                            r_mul_b <= bus.in_b;
                            r_state <= S_CLR;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_mul_sequencer.sv
// Directed bench for karatsuba_mul_sequencer with a behavioural multiplier stub
// whose product and done flag can be forced to model a faulty multiplier.
module tb_karatsuba_mul_sequencer;
    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          busy;
    logic          mul_rst;
    logic          mul_en;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [2*W-1:0] mul_c;
    logic          mul_done;

    logic          fault;
    logic [2*W-1:0] stub_c;
    logic          stub_done;
    int            cyc;
    int            n_checks;
    int            n_pass;

    karatsuba_mul_sequencer_if #(.W(W)) bus ();

    karatsuba_mul_sequencer #(.W(W), .MUL_CYCLES(6)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_busy     (busy),
        .o_mul_rst  (mul_rst),
        .o_mul_en   (mul_en),
        .o_mul_a    (mul_a),
        .o_mul_b    (mul_b),
        .i_mul_c    (mul_c),
        .i_mul_done (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: product settles once enable has been seen.
    always @(posedge clk) begin
        if (mul_rst) begin
            stub_c    <= '0;
            stub_done <= 1'b0;
        end else if (mul_en) begin
            stub_c    <= {32'd0, mul_a} * {32'd0, mul_b};
            stub_done <= 1'b1;
        end
    end
    assign mul_c    = fault ? 64'h123 : stub_c;
    assign mul_done = fault ? 1'b0 : stub_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid, counting edges and enable/clear cycles on the way.
    task automatic wait_out(output int n, output int en_cnt, output int clr_cnt);
        n = 0; en_cnt = 0; clr_cnt = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
            en_cnt  += int'(mul_en);
            clr_cnt += int'(mul_rst);
        end
        if (!bus.out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_c, input logic exp_err);
        int n, en_cnt, clr_cnt, clr0;
        bus.out_ready = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        clr0 = int'(mul_rst);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_out(n, en_cnt, clr_cnt);
        chk({tag, "_latency"}, 64'(n), 64'd8);
        chk({tag, "_en_cycles"}, 64'(en_cnt), 64'd6);
        chk({tag, "_clr_cycles"}, 64'(clr0 + clr_cnt), 64'd1);
        chk({tag, "_c"}, bus.out_c, exp_c);
        chk({tag, "_err"}, 64'(bus.out_err), 64'(exp_err));
        $display("op %s: a=0x%08h b=0x%08h c=0x%016h err=%0d latency=%0d",
                 tag, a, b, bus.out_c, bus.out_err, n);
        tick();
        chk({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n, en_cnt, clr_cnt, last_cyc;
        logic [31:0]  pa [3];
        logic [31:0]  pb [3];
        logic [63:0]  pc [3];

        n_checks = 0; n_pass = 0; cyc = 0; fault = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_mul_rst", 64'(mul_rst), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mul_en", 64'(mul_en), 64'd0);
        chk("rst_out_c", bus.out_c, 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rel_mul_rst", 64'(mul_rst), 64'd0);

        do_op("single", 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 1'b0);
        do_op("full", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);

        // Back-pressure: held product, new operands waiting
        bus.out_ready = 1'b0;
        bus.in_a = 32'd2; bus.in_b = 32'd3; bus.in_valid = 1'b1;
        tick();
        bus.in_a = 32'd4; bus.in_b = 32'd5;
        wait_out(n, en_cnt, clr_cnt);
        chk("bp_c", bus.out_c, 64'd6);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_mul_en", 64'(mul_en), 64'd0);
            chk("bp_out_c", bus.out_c, 64'd6);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_accept_mul_a", 64'(mul_a), 64'd4);
        chk("bp_accept_mul_rst", 64'(mul_rst), 64'd1);
        chk("bp_accept_valid", 64'(bus.out_valid), 64'd0);
        $display("op backpressure: held c=0x6 for 20 cycles, next pair accepted on release");
        wait_out(n, en_cnt, clr_cnt);
        chk("bp_next_latency", 64'(n), 64'd8);
        chk("bp_next_c", bus.out_c, 64'd20);
        tick();
        chk("bp_next_idle", 64'(busy), 64'd0);

        // Back-to-back
        pa[0] = 32'd3;          pb[0] = 32'd5;          pc[0] = 64'd15;
        pa[1] = 32'h8000_0000;  pb[1] = 32'd2;          pc[1] = 64'h1_0000_0000;
        pa[2] = 32'd0;          pb[2] = 32'hDEAD_BEEF;  pc[2] = 64'd0;
        bus.out_ready = 1'b1;
        bus.in_a = pa[0]; bus.in_b = pb[0]; bus.in_valid = 1'b1;
        tick();
        bus.in_a = pa[1]; bus.in_b = pb[1];
        last_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            wait_out(n, en_cnt, clr_cnt);
            chk("b2b_c", bus.out_c, pc[k]);
            if (k > 0) chk("b2b_spacing", 64'(cyc - last_cyc), 64'd9);
            $display("op b2b[%0d]: c=0x%016h at cycle %0d", k, bus.out_c, cyc);
            last_cyc = cyc;
            if (k < 2) begin
                bus.in_a = pa[k+1]; bus.in_b = pb[k+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (k < 2) chk("b2b_accept_a", 64'(mul_a), 64'(pa[k+1]));
        end
        chk("b2b_idle", 64'(busy), 64'd0);

        // Multiplier that never signals done
        fault = 1'b1;
        do_op("fault", 32'd1, 32'd1, 64'h123, 1'b1);
        fault = 1'b0;
        do_op("recover", 32'd2, 32'd2, 64'd4, 1'b0);

        // Asynchronous reset in the third RUN cycle
        bus.in_a = 32'd11; bus.in_b = 32'd13; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        #2;
        chk("mid_run_en", 64'(mul_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_mul_en", 64'(mul_en), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_mul_rst", 64'(mul_rst), 64'd1);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        tick(); tick();
        #2;
        rst = 1'b0;
        #1;
        chk("abort_rel_ready", 64'(bus.in_ready), 64'd1);
        $display("op reset: aborted 11*13 in RUN");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
        end
        do_op("post_reset", 32'd7, 32'd9, 64'd63, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
